// File: rtl/car_security_pkg.sv
// Shared types and encodings for the car security controller blocks.
package car_security_pkg;

  localparam int unsigned VALUE_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    COUNTING,
    EXPIRED
  } timer_state_t;

  // Interval selectors driven by the alarm FSM into the time-parameter block.
  localparam logic [1:0] ARM_DELAY       = 2'b00;
  localparam logic [1:0] DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] ALARM_ON        = 2'b11;

endpackage

// File: rtl/second_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICKS_PER_SECOND cycles.
module second_prescaler #(
  parameter int unsigned TICKS_PER_SECOND = 50_000_000
) (
  input  logic clock,
  input  logic systemResetN,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICKS_PER_SECOND);
  localparam logic [CntW-1:0] LastCnt = CntW'(TICKS_PER_SECOND - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tick = enable && (count_q == LastCnt);

  // Held at zero while disabled so every countdown starts with a full second.
  always_comb begin
    count_d = count_q + CntW'(1);
    if (clear || !enable || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge systemResetN) begin
    if (!systemResetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown timer: latches a value on start, counts it down, pulses expired at zero.
module countdown_timer
  import car_security_pkg::*;
#(
  parameter int unsigned TICKS_PER_SECOND = 50_000_000,
  parameter int unsigned VALUE_WIDTH      = 4
) (
  input  logic                   clock,
  input  logic                   systemResetN,
  input  logic                   startTimer,
  input  logic                   cancelTimer,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic                   busy,
  output logic                   expired,
  output logic                   secondTick,
  output logic [VALUE_WIDTH-1:0] secondsRemaining
);

  timer_state_t           state_q, state_d;
  logic [VALUE_WIDTH-1:0] remaining_q, remaining_d;
  logic                   second_tick_q, second_tick_d;
  logic                   tick;

  second_prescaler #(
    .TICKS_PER_SECOND(TICKS_PER_SECOND)
  ) u_prescaler (
    .clock       (clock),
    .systemResetN(systemResetN),
    .enable      (state_q == COUNTING),
    .clear       (startTimer || cancelTimer),
    .tick        (tick)
  );

  // Priority: start > cancel > tick. A tick coinciding with start/cancel is dropped.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    second_tick_d = 1'b0;
    if (startTimer) begin
      remaining_d = value;
      state_d     = (value != '0) ? COUNTING : EXPIRED;
    end else begin
      case (state_q)
        COUNTING: begin
          if (cancelTimer) begin
            state_d     = IDLE;
            remaining_d = '0;
          end else if (tick) begin
            second_tick_d = 1'b1;
            if (remaining_q == VALUE_WIDTH'(1)) begin
              remaining_d = '0;
              state_d     = EXPIRED;
            end else begin
              remaining_d = remaining_q - VALUE_WIDTH'(1);
            end
          end
        end
        EXPIRED: state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge systemResetN) begin
    if (!systemResetN) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      second_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      second_tick_q <= second_tick_d;
    end
  end

  assign busy             = (state_q == COUNTING);
  assign expired          = (state_q == EXPIRED);
  assign secondTick       = second_tick_q;
  assign secondsRemaining = remaining_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with a 4-cycle second.
module tb_countdown_timer;

  localparam int unsigned Tps = 4;

  logic       clock = 1'b0;
  logic       systemResetN;
  logic       startTimer;
  logic       cancelTimer;
  logic [3:0] value;
  logic       busy;
  logic       expired;
  logic       secondTick;
  logic [3:0] secondsRemaining;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_timer #(
    .TICKS_PER_SECOND(Tps),
    .VALUE_WIDTH     (4)
  ) dut (
    .clock           (clock),
    .systemResetN    (systemResetN),
    .startTimer      (startTimer),
    .cancelTimer     (cancelTimer),
    .value           (value),
    .busy            (busy),
    .expired         (expired),
    .secondTick      (secondTick),
    .secondsRemaining(secondsRemaining)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({busy, expired, secondTick, secondsRemaining});
  endfunction

  // Drive one start edge (E0); value is then scrambled to prove it is ignored.
  task automatic start_timer(input logic [3:0] n);
    startTimer = 1'b1;
    value      = n;
    step(1);
    startTimer = 1'b0;
    value      = 4'd1;
  endtask

  // Check outputs after edges E0+0 .. E0+kmax; stays in cycle after E0+kmax.
  task automatic watch(input string tag, input int n, input int kmax);
    for (int k = 0; k <= kmax; k++) begin
      logic       b, e, t;
      logic [3:0] r;
      b = (n != 0) && (k < Tps * n);
      e = (k == Tps * n);
      t = (n != 0) && (k > 0) && (k % Tps == 0) && (k <= Tps * n);
      r = (k < Tps * n) ? 4'(n - k / Tps) : 4'd0;
      check_eq($sformatf("%s k=%0d", tag, k), outs(), 32'({b, e, t, r}));
      if (k < kmax) step(1);
    end
  endtask

  task automatic count_expired(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step(1);
      if (expired) seen++;
    end
    check_eq(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    systemResetN = 1'b0;
    startTimer   = 1'b0;
    cancelTimer  = 1'b0;
    value        = 4'd0;
    #3;
    check_eq("reset_outputs", outs(), 32'd0);
    #20;
    systemResetN = 1'b1;
    step(2);
    check_eq("idle_after_reset", outs(), 32'd0);

    // Basic countdown of 3 s, then run back to idle.
    start_timer(4'd3);
    watch("basic3", 3, 14);

    // Zero value expires on the very next cycle with no busy phase.
    start_timer(4'd0);
    watch("zero", 0, 4);

    // Cancel mid-count, then start and cancel on the same edge.
    start_timer(4'd5);
    watch("cancel5", 5, 8);
    cancelTimer = 1'b1;
    step(1);
    cancelTimer = 1'b0;
    check_eq("cancel_idle", outs(), 32'd0);
    count_expired("cancel_no_expired", 20);
    cancelTimer = 1'b1;
    start_timer(4'd2);
    cancelTimer = 1'b0;
    watch("start_over_cancel", 2, 10);

    // Restart on the final tick of a 2 s count: reload wins, no pulse.
    start_timer(4'd2);
    watch("collide2", 2, 7);
    start_timer(4'd4);
    watch("reload4", 4, 18);

    // Max value, then start during EXPIRED.
    start_timer(4'hF);
    watch("max15", 15, 59);
    step(1);
    check_eq("max15_expired", outs(), 32'({1'b0, 1'b1, 1'b1, 4'd0}));
    start_timer(4'd1);
    watch("b2b1", 1, 6);

    // Asynchronous reset mid-count.
    start_timer(4'd7);
    watch("rst7", 7, 9);
    systemResetN = 1'b0;
    #1;
    check_eq("async_reset_now", outs(), 32'd0);
    step(2);
    check_eq("reset_held", outs(), 32'd0);
    systemResetN = 1'b1;
    count_expired("reset_no_expired", 40);
    check_eq("reset_idle_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
